display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
Parametrised successor of the calculator display multiplexor. Selects one of NSRC BCD sources by FSM state and snapshots it on frame boundaries so the display never tears. Time-multiplexes the snapshot across DIGITS seven-segment digits using an internal refresh prescaler, and emits a frame pulse (next_data). Adds per-source blinking and leading-zero blanking; sits between the calculator FSM/ALU and the BCD-to-7-segment decoder.

Parameters:
DIGITS, 4, number of BCD digits per source and per display
NSRC, 4, number of selectable sources (num1, op, num2, result by default)
SEL_W, 2, width of sel; must satisfy 2**SEL_W >= NSRC
DIV, 50000, clk cycles per digit-scan tick (>= 2)
BLINK_FRAMES, 64, frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sel  in  SEL_W  source select, normally the FSM curr_state
src_data  in  NSRC*DIGITS*4  packed sources; source k at bits [k*DIGITS*4 +: DIGITS*4]; digit 0 is the least significant nibble
blink_en  in  NSRC  bit k=1: source k blinks when shown
lz_blank  in  1  1 = blank leading zeros
force_update  in  1  immediate re-snapshot and scan restart
data_shown  out  DIGITS*4  current snapshot
digit_an  out  DIGITS  one-hot active-high digit enable
digit_bcd  out  4  BCD value of the active digit
digit_blank  out  1  1 = active digit must be dark
next_data  out  1  one-cycle pulse on every snapshot load

Behaviour:
Reset is synchronous, active-high, one clock, and applies mid-frame. All registers clear:
- prescaler = 0, idx = 0, frame_cnt = 0, blink_phase = 0, sel_q = 0
- data_shown = 0, digit_an = 1 (digit 0 enabled), digit_bcd = 0, digit_blank = 0, next_data = 0

Prescaler:
- Counts 0..DIV-1 and wraps.
- tick = (prescaler == DIV-1), asserted for one cycle.

Scan:
- On tick, idx advances 0..DIGITS-1 and wraps to 0.
- A wrap from DIGITS-1 to 0 is a frame boundary.

Snapshot, at a frame boundary or on force_update:
- If sel < NSRC: data_shown <= source[sel], sel_q <= sel.
- If sel >= NSRC: data_shown <= 0, sel_q <= sel; blink is then treated as 0.
- next_data = 1 in the cycle after the load edge, for exactly one cycle.

force_update:
- Takes priority over a coincident tick.
- Same edge: snapshot, idx <= 0, prescaler <= 0.
- Held high: snapshots every cycle, with next_data high every cycle.

Blink:
- frame_cnt counts frames (force_update does not count).
- At BLINK_FRAMES-1, frame_cnt wraps and blink_phase toggles.
- Blank-all = blink_en[sel_q] && blink_phase.

Leading-zero blanking (only when lz_blank = 1):
- Digit i > 0 is blanked if nibbles i..DIGITS-1 of data_shown are all 0.
- Digit 0 is never LZ-blanked, so value 0 shows a single "0".

Outputs:
- digit_an, digit_bcd and digit_blank are registered and reflect the new idx on the same edge that idx updates.
- digit_bcd = data_shown nibble idx, computed from the post-load data when a snapshot and idx change coincide.
- digit_blank = blank-all OR LZ-blank of idx.

Boundary rules:
- sel changes mid-frame: no visible effect until the next frame boundary.
- Non-BCD nibbles (>9) pass through unchanged.
- Latency from a sel change to display: at most DIGITS*DIV cycles, or 1 cycle with force_update.

Test Plan:
All scenarios use DIGITS=4, NSRC=4, DIV=4, BLINK_FRAMES=2.
1. Reset, then source 0 = 0x1234, sel=0, run 16 cycles -> at cycle 16 the frame boundary gives next_data pulse and data_shown=0x1234; in the following frame digit_an steps 0001, 0010, 0100, 1000 every 4 cycles with digit_bcd 4, 3, 2, 1.
2. Change sel 0->2 (source 2 = 0x0987) mid-frame -> data_shown stays 0x1234 until the next boundary, then 0x0987; exactly one next_data pulse.
3. lz_blank=1, source = 0x0005 -> digit_blank=1 on digits 3, 2, 1 and 0 on digit 0; source 0x0000 -> only digit 0 lit, showing 0.
4. blink_en=4'b0100, sel=2 -> all digits lit for 2 frames, dark for 2 frames, repeating; set blink_en=0 -> never dark.
5. force_update pulsed on the same cycle as a tick, mid-scan -> data_shown updates on that edge, idx=0 (digit_an=0001), prescaler=0, next_data high for 1 cycle.
6. Assert rst during digit 2 of a frame with blink_phase=1 -> the next cycle has all outputs at their reset values; the scan restarts from digit 0, with the next boundary 16 cycles later.

Source files
------------

// File: rtl/display_scan_mux.sv
// Multiplexed seven-segment scanner: snapshots one of NSRC BCD sources per frame
// and drives one digit at a time, with per-source blink and leading-zero blanking.
module display_scan_mux #(
   parameter int DIGITS       = 4,
   parameter int NSRC         = 4,
   parameter int SEL_W        = 2,
   parameter int DIV          = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NSRC*DIGITS*4-1:0] src_data,
   input  logic [NSRC-1:0]          blink_en,
   input  logic                     lz_blank,
   input  logic                     force_update,
   output logic [DIGITS*4-1:0]      data_shown,
   output logic [DIGITS-1:0]        digit_an,
   output logic [3:0]               digit_bcd,
   output logic                     digit_blank,
   output logic                     next_data
);

   localparam int DW    = DIGITS * 4;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PS_W  = $clog2(DIV);
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PS_W-1:0]  prescaler, prescaler_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [FC_W-1:0]  frame_cnt, frame_cnt_n;
   logic             blink_phase, blink_phase_n;
   logic [SEL_W-1:0] sel_q, sel_q_n;
   logic [DW-1:0]    data_n, src_sel;
   logic             tick, frame_end, load, frame_wrap;
   logic             blink_on, lz_hit;
   logic [DIGITS-1:0] an_n;
   logic [3:0]        bcd_n;

   assign tick      = (prescaler == PS_W'(DIV - 1));
   assign frame_end = tick && (idx == IDX_W'(DIGITS - 1));
   assign load      = force_update || frame_end;

   always_comb begin
      src_sel = '0;
      for (int unsigned k = 0; k < NSRC; k++)
         if (sel == SEL_W'(k)) src_sel = src_data[k*DW +: DW];
   end

   always_comb begin
      prescaler_n   = prescaler + 1'b1;
      idx_n         = idx;
      frame_cnt_n   = frame_cnt;
      frame_wrap    = 1'b0;
      if (force_update) begin
         prescaler_n = '0;
         idx_n       = '0;
      end else if (tick) begin
         prescaler_n = '0;
         idx_n       = frame_end ? '0 : idx + 1'b1;
         if (frame_end) begin
            frame_wrap  = (frame_cnt == FC_W'(BLINK_FRAMES - 1));
            frame_cnt_n = frame_wrap ? '0 : frame_cnt + 1'b1;
         end
      end
      blink_phase_n = blink_phase ^ frame_wrap;
      data_n        = load ? src_sel : data_shown;
      sel_q_n       = load ? sel : sel_q;
   end

   // Display outputs are derived from next-state values so a new idx and a
   // fresh snapshot become visible on the same edge.
   always_comb begin
      blink_on = 1'b0;
      for (int unsigned k = 0; k < NSRC; k++)
         if (sel_q_n == SEL_W'(k)) blink_on = blink_en[k] & blink_phase_n;
      lz_hit = lz_blank && (idx_n != '0);
      for (int unsigned i = 0; i < DIGITS; i++)
         if ((IDX_W'(i) >= idx_n) && (data_n[i*4 +: 4] != 4'd0)) lz_hit = 1'b0;
      an_n  = '0;
      bcd_n = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (idx_n == IDX_W'(i)) begin
            an_n[i] = 1'b1;
            bcd_n   = data_n[i*4 +: 4];
         end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler   <= '0;
         idx         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         sel_q       <= '0;
         data_shown  <= '0;
         digit_an    <= DIGITS'(1);
         digit_bcd   <= '0;
         digit_blank <= 1'b0;
         next_data   <= 1'b0;
      end else begin
         prescaler   <= prescaler_n;
         idx         <= idx_n;
         frame_cnt   <= frame_cnt_n;
         blink_phase <= blink_phase_n;
         sel_q       <= sel_q_n;
         data_shown  <= data_n;
         digit_an    <= an_n;
         digit_bcd   <= bcd_n;
         digit_blank <= blink_on | lz_hit;
         next_data   <= load;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized bench for display_scan_mux: outputs are compared every cycle against
// an arithmetic model built from frame position and frame count.
module tb_display_scan_mux;

   localparam int DIGITS = 4, NSRC = 4, SEL_W = 2, DIV = 4, BF = 2;
   localparam int FLEN = DIV * DIGITS;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [SEL_W-1:0]         sel = '0;
   logic [NSRC*DIGITS*4-1:0] src_data = '0;
   logic [NSRC-1:0]          blink_en = '0;
   logic                     lz_blank = 1'b0;
   logic                     force_update = 1'b0;
   logic [DIGITS*4-1:0]      data_shown;
   logic [DIGITS-1:0]        digit_an;
   logic [3:0]               digit_bcd;
   logic                     digit_blank;
   logic                     next_data;

   int n_tests = 0;
   int n_fail  = 0;

   display_scan_mux #(
      .DIGITS(DIGITS), .NSRC(NSRC), .SEL_W(SEL_W), .DIV(DIV), .BLINK_FRAMES(BF)
   ) dut (
      .clk(clk), .rst(rst), .sel(sel), .src_data(src_data), .blink_en(blink_en),
      .lz_blank(lz_blank), .force_update(force_update), .data_shown(data_shown),
      .digit_an(digit_an), .digit_bcd(digit_bcd), .digit_blank(digit_blank),
      .next_data(next_data)
   );

   always #5 clk = ~clk;

   // Reference model: position in the scan, frames since reset, latched snapshot.
   int          m_t = 0;
   int          m_frames = 0;
   int          m_sel = 0;
   logic [15:0] m_shown = '0;
   logic        m_nd = 1'b0;
   logic        m_rst = 1'b1;

   function automatic logic [15:0] pick(input logic [63:0] src, input int s);
      logic [63:0] v;
      v = src >> (16 * s);
      return v[15:0];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_t = 0; m_frames = 0; m_sel = 0; m_shown = '0; m_nd = 1'b0; m_rst = 1'b1;
      end else begin
         m_rst = 1'b0;
         if (force_update) begin
            m_shown = pick(src_data, int'(sel)); m_sel = int'(sel); m_t = 0; m_nd = 1'b1;
         end else if (m_t == FLEN - 1) begin
            m_shown = pick(src_data, int'(sel)); m_sel = int'(sel); m_t = 0; m_nd = 1'b1;
            m_frames++;
         end else begin
            m_t++; m_nd = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_check();
      int          idx;
      logic [15:0] upper;
      logic        blink_all, lz, exp_blank;
      idx       = m_t / DIV;
      upper     = m_shown >> (4 * idx);
      blink_all = blink_en[m_sel] && (((m_frames / BF) % 2) == 1);
      lz        = lz_blank && (idx > 0) && (upper == 16'd0);
      exp_blank = m_rst ? 1'b0 : (blink_all || lz);
      check("data_shown", 32'(data_shown), 32'(m_shown));
      check("next_data", 32'(next_data), 32'(m_nd));
      check("digit_an", 32'(digit_an), 32'(1) << idx);
      check("digit_bcd", 32'(digit_bcd), 32'(upper[3:0]));
      check("digit_blank", 32'(digit_blank), 32'(exp_blank));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      model_check();
   endtask

   logic [3:0] exp_seq [4] = '{4'd4, 4'd3, 4'd2, 4'd1};

   initial begin
      src_data[15:0]  = 16'h1234;
      src_data[47:32] = 16'h0987;
      repeat (2) step();
      rst = 1'b0;
      // First frame boundary lands 16 cycles after reset.
      repeat (15) step();
      check("pre_boundary_shown", 32'(data_shown), 32'h0);
      step();
      check("boundary_shown", 32'(data_shown), 32'h1234);
      check("boundary_pulse", 32'(next_data), 32'd1);
      for (int d = 0; d < 4; d++) begin
         check("scan_an", 32'(digit_an), 32'(1) << d);
         check("scan_bcd", 32'(digit_bcd), 32'(exp_seq[d]));
         repeat (4) step();
      end
      sel = 2'd2;
      repeat (5) step();
      check("sel_no_effect", 32'(data_shown), 32'h1234);

      for (int c = 0; c < 4000; c++) begin
         force_update = 1'b0;
         rst = 1'b0;
         if ($urandom_range(0, 19) == 0) sel = SEL_W'($urandom_range(0, NSRC - 1));
         if ($urandom_range(0, 29) == 0) begin
            for (int k = 0; k < NSRC; k++)
               src_data[k*16 +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) :
                                      16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
         end
         if ($urandom_range(0, 49) == 0) blink_en = NSRC'($urandom);
         if ($urandom_range(0, 49) == 0) lz_blank = 1'($urandom);
         if ($urandom_range(0, 39) == 0) force_update = 1'b1;
         if ($urandom_range(0, 399) == 0) rst = 1'b1;
         step();
      end
      rst = 1'b0;
      force_update = 1'b0;
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
